// File: rtl/bpsk_tx_pkg.sv
// Shared definitions for the BPSK transmitter: FSM encoding, PRBS9
// polynomial constants and the 8-bit antipodal symbol levels.
package bpsk_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // PRBS9: x^9 + x^5 + 1, register length and sequence period
  localparam int PRBS_LEN    = 9;
  localparam int PRBS_PERIOD = 511;
  localparam int PRBS_TAP_HI = 8;
  localparam int PRBS_TAP_LO = 4;

  // Symbol levels for the S(8,7) output format
  localparam logic [7:0] MAP_BIT0 = 8'h7F;
  localparam logic [7:0] MAP_BIT1 = 8'h81;

  // One PRBS9 shift: output bit leaves from the top, feedback enters at the bottom
  function automatic logic [PRBS_LEN-1:0] prbs9_next(input logic [PRBS_LEN-1:0] s);
    return {s[PRBS_LEN-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/bpsk_tx_if.sv
// Control and sample-stream bundle of the BPSK transmitter.
// master drives the controls and observes the stream; slave is the transmitter.
interface bpsk_tx_if #(
  parameter int NB_OUTPUT = 8,
  parameter int NB_BURST  = 16
) ();

  logic                 i_en;
  logic                 i_start;
  logic [NB_BURST-1:0]  i_burst_len;
  logic [NB_BURST-1:0]  i_err_period;
  logic                 i_hold;
  logic [NB_OUTPUT-1:0] o_data;
  logic                 o_valid;
  logic                 o_bit;
  logic                 o_err_inj;
  logic                 o_done;

  modport master (
    output i_en, i_start, i_burst_len, i_err_period, i_hold,
    input  o_data, o_valid, o_bit, o_err_inj, o_done
  );

  modport slave (
    input  i_en, i_start, i_burst_len, i_err_period, i_hold,
    output o_data, o_valid, o_bit, o_err_inj, o_done
  );

endinterface

// File: rtl/bpsk_tx_prbs9_gen.sv
// PRBS9 generator. o_bit is the current top bit; i_load reloads the seed,
// i_adv shifts once. Nothing changes while i_en is low.
module prbs9_gen
  import bpsk_tx_pkg::*;
#(
  parameter logic [PRBS_LEN-1:0] SEED = 9'h1AA
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_load,
  input  logic i_adv,
  output logic o_bit
);

  logic [PRBS_LEN-1:0] lfsr_d;
  logic [PRBS_LEN-1:0] lfsr_q;

  // Next register value: seed reload wins over a shift
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_en) begin
      if (i_load) begin
        lfsr_d = SEED;
      end else if (i_adv) begin
        lfsr_d = prbs9_next(lfsr_q);
      end
    end
  end

  // LFSR register, reset to the seed
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_bit = lfsr_q[PRBS_TAP_HI];

endmodule

// File: rtl/bpsk_tx.sv
// BPSK burst transmitter: PRBS9 bits with optional periodic error injection,
// mapped to +/-(2^NBF-1), oversampled N_PHASES times (held or zero-stuffed).
// All outputs are registered; a symbol appears one cycle after its phase-0 cycle.
module bpsk_tx
  import bpsk_tx_pkg::*;
#(
  parameter int                  NB_OUTPUT  = 8,
  parameter int                  NBF_OUTPUT = 7,
  parameter int                  N_PHASES   = 4,
  parameter logic [PRBS_LEN-1:0] SEED       = 9'h1AA,
  parameter int                  NB_BURST   = 16
) (
  input  logic        clk,
  input  logic        i_rst,
  bpsk_tx_if.slave    bus
);

  localparam int                           PH_W     = (N_PHASES > 1) ? $clog2(N_PHASES) : 1;
  localparam logic [PH_W-1:0]              PH_LAST  = PH_W'(N_PHASES - 1);
  localparam int                           SYM_MAG  = (1 << NBF_OUTPUT) - 1;
  localparam logic signed [NB_OUTPUT-1:0]  SYM_POS  = SYM_MAG[NB_OUTPUT-1:0];
  localparam logic signed [NB_OUTPUT-1:0]  SYM_NEG  = -SYM_POS;

  // Antipodal mapping: bit 0 -> positive full scale, bit 1 -> negative
  function automatic logic signed [NB_OUTPUT-1:0] map_bit(input logic b);
    return b ? SYM_NEG : SYM_POS;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [NB_BURST-1:0] sat_inc(input logic [NB_BURST-1:0] v);
    return (&v) ? v : v + NB_BURST'(1);
  endfunction

  state_t                        state_d,   state_q;
  logic [PH_W-1:0]               phase_d,   phase_q;
  logic [NB_BURST-1:0]           sym_cnt_d, sym_cnt_q;
  logic [NB_BURST-1:0]           err_cnt_d, err_cnt_q;
  logic signed [NB_OUTPUT-1:0]   data_d,    data_q;
  logic                          valid_d,   valid_q;
  logic                          bit_d,     bit_q;
  logic                          err_inj_d, err_inj_q;
  logic                          done_d,    done_q;

  logic lfsr_load;
  logic lfsr_adv;
  logic lfsr_bit;
  logic inject;
  logic tx_bit;

  prbs9_gen #(
    .SEED (SEED)
  ) u_prbs (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_en   (bus.i_en),
    .i_load (lfsr_load),
    .i_adv  (lfsr_adv),
    .o_bit  (lfsr_bit)
  );

  // Next-state, counter and output computation; everything holds while i_en is low
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    bit_d     = bit_q;
    err_inj_d = err_inj_q;
    done_d    = done_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    inject    = 1'b0;
    tx_bit    = 1'b0;

    if (bus.i_en) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          data_d    = '0;
          valid_d   = 1'b0;
          bit_d     = 1'b0;
          err_inj_d = 1'b0;
          if (bus.i_start) begin
            state_d   = ST_RUN;
            phase_d   = '0;
            sym_cnt_d = '0;
            err_cnt_d = '0;
            lfsr_load = 1'b1;
          end
        end

        ST_RUN: begin
          phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
          if (phase_q == '0) begin
            // New symbol: draw the PRBS bit, maybe corrupt it, emit the marker sample
            lfsr_adv  = 1'b1;
            inject    = (bus.i_err_period != '0) &&
                        (err_cnt_q >= bus.i_err_period - NB_BURST'(1));
            tx_bit    = lfsr_bit ^ inject;
            err_cnt_d = inject ? '0 : sat_inc(err_cnt_q);
            sym_cnt_d = sat_inc(sym_cnt_q);
            data_d    = map_bit(tx_bit);
            valid_d   = 1'b1;
            bit_d     = tx_bit;
            err_inj_d = inject;
          end else begin
            // Remaining phases: repeat the current symbol or stuff zeros
            data_d    = bus.i_hold ? map_bit(bit_q) : '0;
            valid_d   = 1'b0;
            err_inj_d = 1'b0;
          end
          // Burst ends on the last phase of the final symbol; length 0 runs forever
          if ((phase_q == PH_LAST) && (bus.i_burst_len != '0) &&
              (sym_cnt_d >= bus.i_burst_len)) begin
            state_d = ST_DONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
      done_d = (state_d == ST_DONE);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      bit_q     <= 1'b0;
      err_inj_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      bit_q     <= bit_d;
      err_inj_q <= err_inj_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_bit     = bit_q;
  assign bus.o_err_inj = err_inj_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_bpsk_tx.sv
// Testbench for bpsk_tx: a table of per-cycle vectors for the opening
// sequence, then hand-written sequences for the multi-cycle cases.
module tb_bpsk_tx;
  import bpsk_tx_pkg::PRBS_PERIOD;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bpsk_tx_if #(.NB_OUTPUT(8), .NB_BURST(16)) bus ();

  bpsk_tx #(
    .NB_OUTPUT  (8),
    .NBF_OUTPUT (7),
    .N_PHASES   (4),
    .SEED       (9'h1AA),
    .NB_BURST   (16)
  ) dut (
    .clk   (clk),
    .i_rst (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       start;
    logic       hold;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_bit;
  } vec_t;

  vec_t       tbl [19];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       ref_bit  [1:1100];
  logic       got_bit  [1:1100];
  logic       got_inj  [1:1100];
  logic [7:0] got_data [1:1100];
  int         got_n;
  int         gap_err;
  int         spacing_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    bus.i_start = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] blen, input logic [15:0] per, input logic hold);
    bus.i_en         = 1'b1;
    bus.i_burst_len  = blen;
    bus.i_err_period = per;
    bus.i_hold       = hold;
    bus.i_start      = 1'b1;
    step();
    bus.i_start      = 1'b0;
  endtask

  // Gather nsym symbols (bounded by max_cyc), tracking 1-in-4 spacing and zero gaps
  task automatic collect(input int nsym, input int max_cyc);
    int last_v;
    last_v      = -1;
    got_n       = 0;
    gap_err     = 0;
    spacing_err = 0;
    for (int c = 0; c < max_cyc && got_n < nsym; c++) begin
      step();
      if (bus.o_valid) begin
        got_n++;
        got_bit[got_n]  = bus.o_bit;
        got_inj[got_n]  = bus.o_err_inj;
        got_data[got_n] = bus.o_data;
        if (last_v >= 0 && (c - last_v) != 4) spacing_err++;
        last_v = c;
      end else if (bus.o_data != 8'h00 || bus.o_err_inj) begin
        gap_err++;
      end
    end
  endtask

  function automatic logic [7:0] lvl(input logic b);
    return b ? 8'h81 : 8'h7F;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] s;
    logic [11:0] snap;
    int cnt;
    int inj_seen;
    int froze_bad;

    // Reference sequence, symbol k = 1..
    s = 9'h1AA;
    for (int k = 1; k <= 1100; k++) begin
      ref_bit[k] = s[8];
      s = {s[7:0], s[8] ^ s[4]};
    end

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h81, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h81, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h7F, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'h81, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 8'h7F, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};

    // Reset with enable and start asserted: reset must win
    rst_n            = 1'b0;
    bus.i_en         = 1'b1;
    bus.i_start      = 1'b1;
    bus.i_burst_len  = 16'd0;
    bus.i_err_period = 16'd0;
    bus.i_hold       = 1'b0;
    step();
    step();
    step();
    check("rst_data",  32'(bus.o_data),    32'h0);
    check("rst_valid", 32'(bus.o_valid),   32'h0);
    check("rst_bit",   32'(bus.o_bit),     32'h0);
    check("rst_inj",   32'(bus.o_err_inj), 32'h0);
    check("rst_done",  32'(bus.o_done),    32'h0);
    rst_n = 1'b1;

    // Opening sequence, continuous, zero-stuffed then held
    for (int i = 0; i < 19; i++) begin
      bus.i_start = tbl[i].start;
      bus.i_hold  = tbl[i].hold;
      step();
      check($sformatf("tbl%0d_data", i),  32'(bus.o_data),    32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_valid", i), 32'(bus.o_valid),   32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_inj", i),   32'(bus.o_err_inj), 32'h0);
      if (tbl[i].exp_valid)
        check($sformatf("tbl%0d_bit", i), 32'(bus.o_bit),     32'(tbl[i].exp_bit));
    end
    bus.i_hold = 1'b0;

    // Full PRBS period plus a few symbols of wrap
    do_reset();
    start_run(16'd0, 16'd0, 1'b0);
    collect(PRBS_PERIOD + 9, 4 * (PRBS_PERIOD + 9) + 20);
    check("cont_count",   32'(got_n),       32'(PRBS_PERIOD + 9));
    check("cont_spacing", 32'(spacing_err), 32'h0);
    check("cont_gaps",    32'(gap_err),     32'h0);
    inj_seen = 0;
    for (int k = 1; k <= got_n; k++) begin
      check($sformatf("cont_bit%0d", k),  32'(got_bit[k]),  32'(ref_bit[k]));
      check($sformatf("cont_data%0d", k), 32'(got_data[k]), 32'(lvl(ref_bit[k])));
      if (got_inj[k]) inj_seen++;
    end
    for (int k = 1; k <= 9 && PRBS_PERIOD + k <= got_n; k++)
      check($sformatf("cont_wrap%0d", k), 32'(got_bit[PRBS_PERIOD + k]), 32'(got_bit[k]));
    check("cont_no_inj", 32'(inj_seen), 32'h0);

    // Error injection every 10 symbols
    do_reset();
    start_run(16'd0, 16'd10, 1'b0);
    collect(30, 200);
    check("err_count", 32'(got_n), 32'd30);
    for (int k = 1; k <= got_n; k++) begin
      check($sformatf("err_inj%0d", k), 32'(got_inj[k]), 32'((k % 10) == 0));
      check($sformatf("err_bit%0d", k), 32'(got_bit[k]), 32'(ref_bit[k] ^ ((k % 10) == 0)));
    end

    // Burst of 5, then a replay from DONE
    do_reset();
    for (int r = 0; r < 2; r++) begin
      start_run(16'd5, 16'd0, 1'b0);
      cnt = 0;
      for (int c = 0; c < 60; c++) begin
        step();
        if (bus.o_valid) begin
          cnt++;
          if (cnt <= 5) check($sformatf("burst%0d_bit%0d", r, cnt), 32'(bus.o_bit), 32'(ref_bit[cnt]));
        end
        if (bus.o_done) break;
      end
      check($sformatf("burst%0d_pulses", r), 32'(cnt),          32'd5);
      check($sformatf("burst%0d_done", r),   32'(bus.o_done),   32'h1);
      check($sformatf("burst%0d_data", r),   32'(bus.o_data),   32'h0);
      for (int c = 0; c < 6; c++) begin
        step();
        if (bus.o_valid) cnt++;
      end
      check($sformatf("burst%0d_after", r),  32'(cnt),          32'd5);
      check($sformatf("burst%0d_stay", r),   32'(bus.o_done),   32'h1);
    end

    // Enable low for 7 cycles in the middle of symbol 2
    do_reset();
    start_run(16'd0, 16'd0, 1'b1);
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 2; c++) begin
      step();
      if (bus.o_valid) cnt++;
    end
    check("freeze_pre", 32'(cnt), 32'd2);
    step();
    snap = {bus.o_data, bus.o_valid, bus.o_bit, bus.o_err_inj, bus.o_done};
    bus.i_en = 1'b0;
    froze_bad = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      if ({bus.o_data, bus.o_valid, bus.o_bit, bus.o_err_inj, bus.o_done} !== snap) froze_bad++;
    end
    check("freeze_hold", 32'(froze_bad), 32'h0);
    check("freeze_data", 32'(bus.o_data), 32'(lvl(ref_bit[2])));
    bus.i_en = 1'b1;
    collect(4, 40);
    check("resume_count",   32'(got_n),       32'd4);
    check("resume_spacing", 32'(spacing_err), 32'h0);
    for (int k = 1; k <= got_n; k++)
      check($sformatf("resume_bit%0d", k), 32'(got_bit[k]), 32'(ref_bit[k + 2]));

    // Reset in the middle of a burst, then restart
    do_reset();
    bus.i_hold = 1'b0;
    start_run(16'd20, 16'd0, 1'b0);
    for (int c = 0; c < 9; c++) step();
    check("midrst_pre_bit", 32'(bus.o_bit), 32'(ref_bit[3]));
    rst_n       = 1'b0;
    bus.i_start = 1'b1;
    step();
    check("midrst_data",  32'(bus.o_data),    32'h0);
    check("midrst_valid", 32'(bus.o_valid),   32'h0);
    check("midrst_bit",   32'(bus.o_bit),     32'h0);
    check("midrst_inj",   32'(bus.o_err_inj), 32'h0);
    check("midrst_done",  32'(bus.o_done),    32'h0);
    rst_n = 1'b1;
    step();
    bus.i_start = 1'b0;
    check("restart_idle", 32'(bus.o_valid), 32'h0);
    step();
    check("restart_data",  32'(bus.o_data),  32'h81);
    check("restart_valid", 32'(bus.o_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpsk_tx.md
BPSK_TX -- requirements
Module: bpsk_tx

Interface
REQ-001 Parameter NB_OUTPUT, 8, output sample width.
REQ-002 Parameter NBF_OUTPUT, 7, output fractional bits, signed S(8,7).
REQ-003 Parameter N_PHASES, 4, oversampling factor (samples per symbol).
REQ-004 Parameter SEED, 9'h1AA, PRBS9 seed.
REQ-005 Parameter NB_BURST, 16, burst-length and error-period width.
REQ-006 clk  input  1  system clock; one clock only.
REQ-007 i_rst  input  1  synchronous, active-low reset.
REQ-008 i_en  input  1  enable; low freezes all state and holds outputs.
REQ-009 i_start  input  1  start/restart burst (level sampled).
REQ-010 i_burst_len  input  NB_BURST  symbols per burst; 0 = continuous.
REQ-011 i_err_period  input  NB_BURST  inject one bit error every N symbols; 0 = none.
REQ-012 i_hold  input  1  1 = symbol held on all phases, 0 = zero-stuffed.
REQ-013 o_data  output  NB_OUTPUT  transmitted sample.
REQ-014 o_valid  output  1  high on the first sample (phase 0) of each symbol.
REQ-015 o_bit  output  1  transmitted bit after injection, aligned with o_valid.
REQ-016 o_err_inj  output  1  high with o_valid when that symbol carries an injected error.
REQ-017 o_done  output  1  high while in DONE.

Function
REQ-018 FSM states IDLE, RUN, DONE; encoded in 2 bits.
REQ-019 IDLE/DONE -> RUN when i_en && i_start; the LFSR reloads SEED and the symbol, error and phase counters clear in that same cycle.
REQ-020 RUN -> DONE when i_en, phase_cnt==N_PHASES-1, i_burst_len!=0 and symbol count reaches i_burst_len.
REQ-021 i_start while in RUN is ignored; i_burst_len==0 never leaves RUN.
REQ-022 i_en low in any state: no transition, no counter or LFSR update, outputs hold their last value.
REQ-023 Phase counter 0..N_PHASES-1 advances each enabled RUN cycle and wraps to 0.
REQ-024 PRBS9: bit = lfsr[8]; on each enabled RUN cycle with phase_cnt==0 the register becomes {lfsr[7:0], lfsr[8]^lfsr[4]}; period 511.
REQ-025 Error counter increments per symbol; when i_err_period!=0 and the count is >= i_err_period-1, the bit is inverted, o_err_inj is asserted and the counter clears. The >= rule covers a period reduced mid-run.
REQ-026 Mapping: bit 0 -> +(2^NBF_OUTPUT-1) = 8'h7F; bit 1 -> -(2^NBF_OUTPUT-1) = 8'h81. MSB equals the bit.
REQ-027 Non-zero phases: o_data repeats the symbol if i_hold=1, else 8'h00. o_valid=0 and o_err_inj=0.
REQ-028 All outputs are registered; latency is one cycle from the enabled phase-0 cycle to o_valid/o_data.
REQ-029 In IDLE and DONE, o_data=0, o_valid=0, o_bit=0, o_err_inj=0.
REQ-030 The symbol counter saturates at 2^NB_BURST-1 in continuous mode, with no wrap effects.

Reset
REQ-031 With i_rst=0 at a clk edge: state=IDLE, lfsr=SEED, all counters 0, all outputs 0. This applies mid-burst and overrides i_en/i_start.
REQ-032 The first RUN cycle after reset starts on phase 0.

Structure
REQ-033 Shared package: state encodings, PRBS9 taps/length (9, 511), mapping constants 8'h7F/8'h81.
REQ-034 One sub-module, prbs9_gen (LFSR with seed, en and advance inputs), instantiated once.

Verification
REQ-035 Reset, then i_en=1, i_start=1, burst 0, period 0, hold 0. Required: first three o_valid symbols o_data=8'h81, 8'h81, 8'h7F; o_valid 1-in-4 cycles; zeros between.
REQ-036 Continuous run of 511 symbols. Required: symbol 512 equals symbol 1, and no o_err_inj.
REQ-037 i_err_period=10. Required: o_err_inj on symbols 10, 20, 30, with o_bit inverted versus the reference PRBS9 there only.
REQ-038 i_burst_len=5. Required: exactly 5 o_valid pulses, then o_done=1 and o_data=0. A second i_start replays the same 5 symbols from SEED.
REQ-039 i_en low for 7 cycles mid-symbol. Required: outputs frozen, and the sequence resumes with no skipped or repeated symbol.
REQ-040 i_rst low mid-burst with i_en=1. Required: next cycle IDLE with all outputs 0, and a restart gives 8'h81 first again.
